parking_lot_occupancy: RTL and testbench

- Downstream consumer of the parking-lot enter/exit detector.
- Takes its `enter`/`exit` indications and keeps a running count of cars in the lot, bounded by a fixed capacity.
- Raises full, empty and sticky error flags.
- Drives six active-low 7-segment digits with the count, plus a "FUL" banner when full.

---
 rtl/parking_pkg.sv | 25 ++
 rtl/seg7_digit.sv | 18 +
 rtl/parking_lot_occupancy.sv | 128 ++++++++++++
 tb/tb_parking_lot_occupancy.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared constants for the parking-lot occupancy block: 7-segment glyphs
// (active-low, bit order {g,f,e,d,c,b,a}) and the capacity ceiling.
package parking_pkg;

    localparam int unsigned MAX_CAPACITY = 99;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_L     = 7'b1000111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage

// File: rtl/seg7_digit.sv
// Single decimal digit to active-low 7-segment decoder with a blank override.
module seg7_digit
    import parking_pkg::*;
(
    input  logic [3:0] i_value,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Decode the digit; out-of-range values and explicit blanking show nothing
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank && (i_value <= 4'd9)) begin
            o_seg = SEG_DIGIT[i_value];
        end
    end

endmodule

// File: rtl/parking_lot_occupancy.sv
// Running car count for a parking lot fed by enter/exit indications.
// Rising edges of enter/exit move the count, saturating at 0 and CAPACITY
// with sticky overflow/underflow flags; the count and a "FUL" banner are
// shown on six active-low 7-segment digits. CAPACITY must lie in 1..99.
module parking_lot_occupancy
    import parking_pkg::*;
#(
    parameter  int unsigned CAPACITY = 16,
    localparam int unsigned CW       = $clog2(CAPACITY + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enter,
    input  logic          exit,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf_err,
    output logic          unf_err,
    output logic [6:0]    HEX0,
    output logic [6:0]    HEX1,
    output logic [6:0]    HEX2,
    output logic [6:0]    HEX3,
    output logic [6:0]    HEX4,
    output logic [6:0]    HEX5
);

    localparam logic [CW-1:0] CAP_CW = CW'(CAPACITY);

    logic          r_enter_q;
    logic          r_exit_q;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_ovf_err;
    logic          r_unf_err;

    logic          w_inc;
    logic          w_dec;
    logic [CW-1:0] w_count_nxt;
    logic          w_ovf_set;
    logic          w_unf_set;

    logic [6:0]    w_count_wide;
    logic [3:0]    w_tens;
    logic [3:0]    w_ones;
    logic          w_tens_blank;

    // Edge detect and saturating next-count; simultaneous edges cancel
    always_comb begin
        w_inc       = enter & ~r_enter_q;
        w_dec       = exit & ~r_exit_q;
        w_count_nxt = r_count;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        case ({w_inc, w_dec})
            2'b10: begin
                if (r_count == CAP_CW) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_count_nxt = r_count + CW'(1);
                end
            end
            2'b01: begin
                if (r_count == '0) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_count_nxt = r_count - CW'(1);
                end
            end
            default: begin
                w_count_nxt = r_count;
            end
        endcase
    end

    // State update; edge registers track the inputs even during reset so a
    // level held across reset release is not mistaken for a new event
    always_ff @(posedge clk) begin
        r_enter_q <= enter;
        r_exit_q  <= exit;
        if (reset) begin
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_full    <= (w_count_nxt == CAP_CW);
            r_empty   <= (w_count_nxt == '0);
            r_ovf_err <= r_ovf_err | w_ovf_set;
            r_unf_err <= r_unf_err | w_unf_set;
        end
    end

    assign count   = r_count;
    assign full    = r_full;
    assign empty   = r_empty;
    assign ovf_err = r_ovf_err;
    assign unf_err = r_unf_err;

    // Decimal split of the count; count never exceeds 99 so 7 bits suffice
    always_comb begin
        w_count_wide = 7'(r_count);
        w_tens       = 4'(w_count_wide / 7'd10);
        w_ones       = 4'(w_count_wide % 7'd10);
        w_tens_blank = (w_tens == 4'd0);
    end

    seg7_digit u_tens (
        .i_value (w_tens),
        .i_blank (w_tens_blank),
        .o_seg   (HEX1)
    );

    seg7_digit u_ones (
        .i_value (w_ones),
        .i_blank (1'b0),
        .o_seg   (HEX0)
    );

    assign HEX2 = SEG_BLANK;
    assign HEX3 = r_full ? SEG_L : SEG_BLANK;
    assign HEX4 = r_full ? SEG_U : SEG_BLANK;
    assign HEX5 = r_full ? SEG_F : SEG_BLANK;

endmodule

// File: tb/tb_parking_lot_occupancy.sv
// Bench for parking_lot_occupancy: a CAPACITY=16 and a CAPACITY=1 instance
// share one stimulus stream and are compared against an occupancy model.
module tb_parking_lot_occupancy;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic enter;
    logic ex;

    logic [4:0] a_count;
    logic       a_full, a_empty, a_ovf, a_unf;
    logic [6:0] a_hex [6];

    logic [0:0] b_count;
    logic       b_full, b_empty, b_ovf, b_unf;
    logic [6:0] b_hex [6];

    parking_lot_occupancy #(.CAPACITY(16)) u_dut16 (
        .clk(clk), .reset(reset), .enter(enter), .exit(ex),
        .count(a_count), .full(a_full), .empty(a_empty),
        .ovf_err(a_ovf), .unf_err(a_unf),
        .HEX0(a_hex[0]), .HEX1(a_hex[1]), .HEX2(a_hex[2]),
        .HEX3(a_hex[3]), .HEX4(a_hex[4]), .HEX5(a_hex[5])
    );

    parking_lot_occupancy #(.CAPACITY(1)) u_dut1 (
        .clk(clk), .reset(reset), .enter(enter), .exit(ex),
        .count(b_count), .full(b_full), .empty(b_empty),
        .ovf_err(b_ovf), .unf_err(b_unf),
        .HEX0(b_hex[0]), .HEX1(b_hex[1]), .HEX2(b_hex[2]),
        .HEX3(b_hex[3]), .HEX4(b_hex[4]), .HEX5(b_hex[5])
    );

    // Reference glyphs, active-low {g,f,e,d,c,b,a}
    logic [6:0] glyph_digit [10];
    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_F     = 7'b0001110;
    localparam logic [6:0] G_U     = 7'b1000001;
    localparam logic [6:0] G_L     = 7'b1000111;

    int n_chk = 0;
    int n_err = 0;

    // Model: occupancy, sticky errors and last seen input levels
    int caps  [2] = '{16, 1};
    int m_cnt [2];
    int m_ovf [2];
    int m_unf [2];
    bit m_prev_e;
    bit m_prev_x;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_hex(input int cnt, input int cap, input int idx);
        bit is_full;
        int tens;
        is_full = (cnt == cap);
        tens    = cnt / 10;
        case (idx)
            0:       return int'(glyph_digit[cnt % 10]);
            1:       return (tens == 0) ? int'(G_BLANK) : int'(glyph_digit[tens]);
            2:       return int'(G_BLANK);
            3:       return is_full ? int'(G_L) : int'(G_BLANK);
            4:       return is_full ? int'(G_U) : int'(G_BLANK);
            default: return is_full ? int'(G_F) : int'(G_BLANK);
        endcase
    endfunction

    task automatic model_update(input bit r, input bit e, input bit x);
        bit rise_e;
        bit rise_x;
        rise_e = e && !m_prev_e;
        rise_x = x && !m_prev_x;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_cnt[k] = 0;
                m_ovf[k] = 0;
                m_unf[k] = 0;
            end else if (rise_e && !rise_x) begin
                if (m_cnt[k] < caps[k]) m_cnt[k] = m_cnt[k] + 1;
                else                    m_ovf[k] = 1;
            end else if (rise_x && !rise_e) begin
                if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
                else              m_unf[k] = 1;
            end
        end
        m_prev_e = e;
        m_prev_x = x;
    endtask

    task automatic check_all();
        check("cnt16",   int'(a_count), m_cnt[0]);
        check("full16",  int'(a_full),  int'(m_cnt[0] == 16));
        check("empty16", int'(a_empty), int'(m_cnt[0] == 0));
        check("ovf16",   int'(a_ovf),   m_ovf[0]);
        check("unf16",   int'(a_unf),   m_unf[0]);
        check("cnt1",    int'(b_count), m_cnt[1]);
        check("full1",   int'(b_full),  int'(m_cnt[1] == 1));
        check("empty1",  int'(b_empty), int'(m_cnt[1] == 0));
        check("ovf1",    int'(b_ovf),   m_ovf[1]);
        check("unf1",    int'(b_unf),   m_unf[1]);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("hex%0d_16", i), int'(a_hex[i]), exp_hex(m_cnt[0], 16, i));
            check($sformatf("hex%0d_1", i),  int'(b_hex[i]), exp_hex(m_cnt[1], 1, i));
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rise
    task automatic step(input bit r, input bit e, input bit x);
        @(negedge clk);
        reset = r;
        enter = e;
        ex    = x;
        @(posedge clk);
        model_update(r, e, x);
        #1;
        check_all();
    endtask

    task automatic pulse_enter();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_exit();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        glyph_digit = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        reset = 1'b1;
        enter = 1'b0;
        ex    = 1'b0;
        m_prev_e = 1'b0;
        m_prev_x = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
        end

        // Reset state
        step(1'b1, 1'b0, 1'b0);
        check("rst_hex0", int'(a_hex[0]), int'(7'b1000000));
        check("rst_empty", int'(a_empty), 1);

        // Three spaced pulses
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check("pulse_cnt", int'(a_count), i + 1);
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        check("three_hex0", int'(a_hex[0]), int'(7'b0110000));
        check("three_hex1", int'(a_hex[1]), int'(G_BLANK));

        // Fill to capacity and beyond
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) pulse_enter();
        check("fill_cnt",  int'(a_count), 16);
        check("fill_full", int'(a_full), 1);
        check("fill_ovf",  int'(a_ovf), 1);
        check("fill_hex5", int'(a_hex[5]), int'(G_F));
        check("fill_hex1", int'(a_hex[1]), int'(7'b1111001));
        check("fill_hex0", int'(a_hex[0]), int'(7'b0000010));

        // Underflow then recovery, error stays sticky
        step(1'b1, 1'b0, 1'b0);
        pulse_exit();
        check("unf_set", int'(a_unf), 1);
        pulse_enter();
        check("unf_sticky_cnt", int'(a_count), 1);
        check("unf_sticky", int'(a_unf), 1);

        // Held level counts once; simultaneous edges cancel
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("held_cnt", int'(a_count), 1);
        for (int i = 0; i < 4; i++) pulse_enter();
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("both_cnt", int'(a_count), 5);
        check("both_ovf", int'(a_ovf), 0);

        // Reset with enter held through release
        pulse_enter();
        step(1'b0, 1'b1, 1'b0);
        check("pre_rst_cnt", int'(a_count), 7);
        step(1'b1, 1'b1, 1'b0);
        check("mid_rst_cnt", int'(a_count), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        check("hold_after_rst", int'(a_count), 0);
        step(1'b0, 1'b0, 1'b0);
        pulse_enter();
        check("after_rst_pulse", int'(a_count), 1);

        // Capacity-one instance
        step(1'b1, 1'b0, 1'b0);
        pulse_enter();
        check("cap1_full",  int'(b_full), 1);
        check("cap1_empty", int'(b_empty), 0);
        pulse_exit();
        check("cap1_full2",  int'(b_full), 0);
        check("cap1_empty2", int'(b_empty), 1);
        pulse_exit();
        check("cap1_unf", int'(b_unf), 1);

        // Randomized phases: enter-biased, exit-biased, uniform
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            int pe;
            int px;
            bit r;
            pe = (i < 500) ? 60 : (i < 1000) ? 25 : 45;
            px = (i < 500) ? 25 : (i < 1000) ? 60 : 45;
            r  = ($urandom_range(0, 199) == 0);
            step(r, ($urandom_range(0, 99) < pe), ($urandom_range(0, 99) < px));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
